// File: rtl/quad_decoder.sv
// ============================================================================
//  Module   : quad_decoder
//  Brief    : Quadrature encoder front-end. Emits a step pulse with a direction
//             flag, keeps a wrapping position and flags illegal transitions.
//             Optional glitch filter: QUAD_DECODER_GLITCH_FILTER_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_decoder #(
  parameter int POS_W    = 16,
  parameter int FILT_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_a,
  input  logic             ch_b,
  input  logic             clr,
  input  logic             err_clr,
  output logic             step,
  output logic             up,
  output logic [POS_W-1:0] pos,
  output logic             err
);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

`ifdef QUAD_DECODER_GLITCH_FILTER_EN
  localparam int c_INIT_CYC = 2 + FILT_CYC;
  localparam int c_FCNT_W   = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
`else
  localparam int c_INIT_CYC = 2;
`endif
  localparam int c_ICNT_W = $clog2(c_INIT_CYC);

  // Marker block: present in the hierarchy only for out-of-range parameters.
  generate
    if (POS_W < 2 || FILT_CYC < 1) begin : g_param_range_invalid
    end
  endgenerate

  // Bit 1 carries channel A, bit 0 channel B throughout.
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          w_chs;
  logic [1:0]          w_phase;
  logic [1:0]          w_delta;
  logic                w_run;
  logic                w_cnt_up;
  logic                w_cnt_dn;
  logic                w_illegal;

  state_t              r_state;
  logic [c_ICNT_W-1:0] r_icnt;
  logic [1:0]          r_prev;
  logic                r_step;
  logic                r_up;
  logic [POS_W-1:0]    r_pos;
  logic                r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {ch_a, ch_b};
      r_sync2 <= r_sync1;
    end
  end

`ifdef QUAD_DECODER_GLITCH_FILTER_EN
  // A new level is accepted only after it has been held FILT_CYC cycles.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_filt
      logic [c_FCNT_W-1:0] r_cnt;
      logic                r_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt <= '0;
          r_q   <= 1'b0;
        end else if (r_sync2[g] == r_q) begin
          r_cnt <= '0;
        end else if (r_cnt == c_FCNT_W'(FILT_CYC - 1)) begin
          r_q   <= r_sync2[g];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_FCNT_W'(1);
        end
      end

      assign w_chs[g] = r_q;
    end
  endgenerate
`else
  assign w_chs = r_sync2;
`endif

  // Gray code to phase: 00->0, 01->1, 11->2, 10->3.
  assign w_phase   = {w_chs[1], w_chs[1] ^ w_chs[0]};
  assign w_delta   = w_phase - r_prev;
  assign w_run     = (r_state == S_RUN);
  assign w_cnt_up  = w_run && (w_delta == 2'd1);
  assign w_cnt_dn  = w_run && (w_delta == 2'd3);
  assign w_illegal = w_run && (w_delta == 2'd2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_icnt  <= '0;
      r_prev  <= 2'd0;
      r_step  <= 1'b0;
      r_up    <= 1'b1;
      r_pos   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_icnt == c_ICNT_W'(c_INIT_CYC - 1)) begin
            r_prev  <= w_phase;
            r_state <= S_RUN;
          end else begin
            r_icnt <= r_icnt + c_ICNT_W'(1);
          end
        end
        S_RUN: begin
          r_prev <= w_phase;
          if (w_cnt_up || w_cnt_dn) begin
            r_step <= 1'b1;
            r_up   <= w_cnt_up;
          end
        end
        default: r_state <= S_INIT;
      endcase

      if (clr)
        r_pos <= '0;
      else if (w_cnt_up)
        r_pos <= r_pos + POS_W'(1);
      else if (w_cnt_dn)
        r_pos <= r_pos - POS_W'(1);

      if (w_illegal)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;
    end
  end

  assign step = r_step;
  assign up   = r_up;
  assign pos  = r_pos;
  assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
//  Module   : tb_quad_decoder
//  Brief    : Scoreboard bench for quad_decoder; expectations queued at stimulus
//             time and compared on the cycle the result is due.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_decoder;

  localparam int POS_W    = 16;
  localparam int FILT_CYC = 3;
`ifdef QUAD_DECODER_GLITCH_FILTER_EN
  localparam int c_LAT  = 3 + FILT_CYC;
  localparam int c_INIT = 2 + FILT_CYC;
`else
  localparam int c_LAT  = 3;
  localparam int c_INIT = 2;
`endif
  localparam int c_HOLD = c_LAT + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             ch_a;
  logic             ch_b;
  logic             clr;
  logic             err_clr;
  logic             step;
  logic             up;
  logic [POS_W-1:0] pos;
  logic             err;

  quad_decoder #(.POS_W(POS_W), .FILT_CYC(FILT_CYC)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .ch_a    (ch_a),
    .ch_b    (ch_b),
    .clr     (clr),
    .err_clr (err_clr),
    .step    (step),
    .up      (up),
    .pos     (pos),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic             step;
    logic             up;
    logic             err;
    logic [POS_W-1:0] pos;
  } exp_t;

  exp_t             q[$];
  int               cyc = 0;
  int               n_checks = 0;
  int               n_errors = 0;
  bit               sb_on = 1'b0;

  logic [1:0]       m_prev;
  logic [POS_W-1:0] m_pos;
  logic             m_up;
  logic             m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sb_on) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("step", step, e.step);
        check("up",   up,   e.up);
        check("pos",  pos,  e.pos);
        check("err",  err,  e.err);
      end else begin
        check("idle_step", step, 1'b0);
      end
    end
  end

  task automatic model_reset();
    m_prev = 2'd0;
    m_pos  = '0;
    m_up   = 1'b1;
    m_err  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drive a new channel level; optionally land clr/err_clr on the result edge.
  task automatic move(input logic a, input logic b, input int hold,
                      input bit clr_hit, input bit errclr_hit);
    logic [1:0] ph;
    logic [1:0] d;
    exp_t       e;
    ch_a = a;
    ch_b = b;
    ph = {a, a ^ b};
    d  = ph - m_prev;
    m_prev = ph;
    if (d == 2'd1) begin
      m_pos = m_pos + 1'b1;
      m_up  = 1'b1;
    end else if (d == 2'd3) begin
      m_pos = m_pos - 1'b1;
      m_up  = 1'b0;
    end else if (d == 2'd2) begin
      m_err = 1'b1;
    end
    if (clr_hit) m_pos = '0;
    e.due  = cyc + c_LAT;
    e.step = d[0];
    e.up   = m_up;
    e.pos  = m_pos;
    e.err  = m_err;
    q.push_back(e);
    for (int i = 0; i < hold; i++) begin
      if (i == c_LAT - 1) begin
        clr     = clr_hit;
        err_clr = errclr_hit;
      end
      @(posedge clk); #1;
      clr     = 1'b0;
      err_clr = 1'b0;
    end
  endtask

  task automatic ctrl_pulse(input bit is_clr);
    exp_t e;
    if (is_clr) begin
      clr   = 1'b1;
      m_pos = '0;
    end else begin
      err_clr = 1'b1;
      m_err   = 1'b0;
    end
    e.due  = cyc + 1;
    e.step = 1'b0;
    e.up   = m_up;
    e.pos  = m_pos;
    e.err  = m_err;
    q.push_back(e);
    @(posedge clk); #1;
    clr     = 1'b0;
    err_clr = 1'b0;
    idle(2);
  endtask

  task automatic check_reset_vals();
    check("rst_step", step, 1'b0);
    check("rst_up",   up,   1'b1);
    check("rst_pos",  pos,  '0);
    check("rst_err",  err,  1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ch_a = 1'b0; ch_b = 1'b0; clr = 1'b0; err_clr = 1'b0;
    model_reset();

    // Channels toggle while reset is held.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ch_a = i[0];
      ch_b = i[1];
    end
    check_reset_vals();
    ch_a = 1'b0; ch_b = 1'b0;
    idle(2);
    rst   = 1'b1;
    sb_on = 1'b1;
    idle(c_INIT + 3);

    // Forward rotation.
    move(1'b0, 1'b1, c_HOLD, 1'b0, 1'b0);
    move(1'b1, 1'b1, c_HOLD, 1'b0, 1'b0);
    move(1'b1, 1'b0, c_HOLD, 1'b0, 1'b0);
    move(1'b0, 1'b0, c_HOLD, 1'b0, 1'b0);

    // Reverse through zero and back.
    ctrl_pulse(1'b1);
    move(1'b1, 1'b0, c_HOLD, 1'b0, 1'b0);
    move(1'b0, 1'b0, c_HOLD, 1'b0, 1'b0);

    // Illegal transitions and sticky error.
    move(1'b1, 1'b1, c_HOLD, 1'b0, 1'b0);
    ctrl_pulse(1'b0);
    move(1'b0, 1'b0, c_HOLD, 1'b0, 1'b1);
    ctrl_pulse(1'b0);

    // Up to pos=7, then clr lands on the step edge.
    for (int i = 0; i < 7; i++) begin
      case (i % 4)
        0: move(1'b0, 1'b1, c_HOLD, 1'b0, 1'b0);
        1: move(1'b1, 1'b1, c_HOLD, 1'b0, 1'b0);
        2: move(1'b1, 1'b0, c_HOLD, 1'b0, 1'b0);
        default: move(1'b0, 1'b0, c_HOLD, 1'b0, 1'b0);
      endcase
    end
    move(1'b0, 1'b0, c_HOLD, 1'b1, 1'b0);

    // One-cycle glitch on channel A.
`ifdef QUAD_DECODER_GLITCH_FILTER_EN
    ch_a = 1'b1;
    @(posedge clk); #1;
    ch_a = 1'b0;
    idle(c_HOLD + 2);
    check("glitch_pos", pos, m_pos);
`else
    move(1'b1, 1'b0, 1, 1'b0, 1'b0);
    move(1'b0, 1'b0, c_HOLD, 1'b0, 1'b0);
`endif

    // Reset mid-operation, then restart.
    sb_on = 1'b0;
    rst   = 1'b0;
    ch_b  = 1'b1;
    idle(2);
    check_reset_vals();
    ch_b = 1'b0;
    idle(2);
    model_reset();
    rst   = 1'b1;
    sb_on = 1'b1;
    idle(c_INIT + 3);
    move(1'b0, 1'b1, c_HOLD, 1'b0, 1'b0);

    check("sb_drain", q.size(), 0);
    sb_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
